// File: rtl/rtl_kernel_1_example_burst_issuer_if.sv
// ---------------------------------------------------------------------------
// rtl_kernel_1_example_burst_issuer_if
// Bundles the control, AR-command and response-tracking signals of the
// burst issuer.
//   master : the issuer's view (drives cmd_*, ctrl_done, busy, outstanding,
//            rsp_err; receives ctrl_start/addr/size, cmd_ready, rsp_done)
//   slave  : the environment's view (kernel control + AXI read master)
// ---------------------------------------------------------------------------
interface rtl_kernel_1_example_burst_issuer_if #(
    parameter int C_ADDR_WIDTH      = 64,
    parameter int C_XFER_SIZE_WIDTH = 32,
    parameter int C_MAX_OUTSTANDING = 16
);
    localparam int CW = $clog2(C_MAX_OUTSTANDING) + 1;

    logic                         ctrl_start;
    logic [C_ADDR_WIDTH-1:0]      ctrl_addr_offset;
    logic [C_XFER_SIZE_WIDTH-1:0] ctrl_xfer_size;
    logic                         ctrl_done;
    logic                         busy;
    logic                         cmd_valid;
    logic                         cmd_ready;
    logic [C_ADDR_WIDTH-1:0]      cmd_addr;
    logic [7:0]                   cmd_len;
    logic                         rsp_done;
    logic [CW-1:0]                outstanding;
    logic                         rsp_err;

    modport master (
        input  ctrl_start, ctrl_addr_offset, ctrl_xfer_size, cmd_ready, rsp_done,
        output ctrl_done, busy, cmd_valid, cmd_addr, cmd_len, outstanding, rsp_err
    );

    modport slave (
        output ctrl_start, ctrl_addr_offset, ctrl_xfer_size, cmd_ready, rsp_done,
        input  ctrl_done, busy, cmd_valid, cmd_addr, cmd_len, outstanding, rsp_err
    );
endinterface

// File: rtl/rtl_kernel_1_example_burst_issuer.sv
// ---------------------------------------------------------------------------
// rtl_kernel_1_example_burst_issuer
// Splits one host-programmed read transfer into AR bursts of at most
// C_BURST_LEN beats, limits bursts in flight to C_MAX_OUTSTANDING with a
// credit counter, and pulses ctrl_done once all bursts have returned.
// Ports:
//   clk  : kernel clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : master modport of rtl_kernel_1_example_burst_issuer_if
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module rtl_kernel_1_example_burst_issuer #(
    parameter int C_ADDR_WIDTH      = 64,
    parameter int C_DATA_WIDTH      = 512,
    parameter int C_XFER_SIZE_WIDTH = 32,
    parameter int C_BURST_LEN       = 64,
    parameter int C_MAX_OUTSTANDING = 16
) (
    input  logic clk,
    input  logic rst,
    rtl_kernel_1_example_burst_issuer_if.master bus
);
    localparam int BPB     = C_DATA_WIDTH / 8;
    localparam int LOG_BPB = $clog2(BPB);
    localparam int CW      = $clog2(C_MAX_OUTSTANDING) + 1;
    localparam int XW      = C_XFER_SIZE_WIDTH;
    localparam int AW      = C_ADDR_WIDTH;

    localparam logic [CW-1:0] MAX_CNT = CW'(C_MAX_OUTSTANDING);
    localparam logic [XW-1:0] BL_X    = XW'(C_BURST_LEN);
    localparam logic [7:0]    BL_M1   = 8'(C_BURST_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    // AXI len field (beats-1) for the next burst given the beats still to issue.
    function automatic logic [7:0] f_burst_len(input logic [XW-1:0] remaining);
        logic [7:0] len;
        if (remaining == {XW{1'b0}}) begin
            len = 8'd0;
        end else if (remaining >= BL_X) begin
            len = BL_M1;
        end else begin
            len = 8'(remaining - {{(XW-1){1'b0}}, 1'b1});
        end
        return len;
    endfunction

    state_e          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [XW-1:0]   rem_q, rem_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_q, err_d;
    logic [7:0]      len_q, len_d;
    logic            cmd_valid_q, cmd_valid_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;

    logic            start_acc_s;
    logic            hs_s;
    logic [8:0]      len_plus1_s;
    logic [XW-1:0]   beats_s;
    logic [AW-1:0]   step_s;

    assign start_acc_s = (state_q == S_IDLE) && bus.ctrl_start;
    assign hs_s        = cmd_valid_q && bus.cmd_ready;
    assign len_plus1_s = {1'b0, len_q} + 9'd1;
    // Ceiling divide by BPB without widening: whole beats plus one for any tail.
    assign beats_s     = (bus.ctrl_xfer_size >> LOG_BPB)
                       + {{(XW-1){1'b0}}, |bus.ctrl_xfer_size[LOG_BPB-1:0]};
    assign step_s      = AW'(len_plus1_s) << LOG_BPB;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_acc_s) begin
                    state_d = (beats_s == {XW{1'b0}}) ? S_DONE : S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                // The handshake that consumes the last beats ends issuing.
                if (hs_s && (rem_q == XW'(len_plus1_s))) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_DRAIN: begin
                if (cnt_q == {CW{1'b0}}) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Address/remaining-beat bookkeeping and the credit counter.
    always_comb begin
        addr_d = addr_q;
        rem_d  = rem_q;
        cnt_d  = cnt_q;
        err_d  = err_q;
        if (start_acc_s) begin
            addr_d = bus.ctrl_addr_offset;
            rem_d  = beats_s;
            err_d  = 1'b0;
        end else if (hs_s) begin
            addr_d = addr_q + step_s;
            rem_d  = rem_q - XW'(len_plus1_s);
        end else begin
            addr_d = addr_q;
            rem_d  = rem_q;
        end
        case ({hs_s, bus.rsp_done})
            2'b10: cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
            2'b01: begin
                // A response with nothing in flight is a protocol error; the
                // count must not underflow.
                if (cnt_q == {CW{1'b0}}) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
                end
            end
            default: cnt_d = cnt_q;
        endcase
    end

    // FSM output decode, evaluated on next-state values so outputs can be registered.
    // cmd_valid uses the next count, i.e. the registered count of the cycle
    // it is presented in, so a response never bypasses into the same cycle.
    always_comb begin
        cmd_valid_d = (state_d == S_ISSUE) && (cnt_d < MAX_CNT);
        done_d      = (state_d == S_DONE);
        busy_d      = (state_d != S_IDLE);
        len_d       = f_burst_len(rem_d);
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q      <= {AW{1'b0}};
            rem_q       <= {XW{1'b0}};
            cnt_q       <= {CW{1'b0}};
            err_q       <= 1'b0;
            len_q       <= 8'd0;
            cmd_valid_q <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            len_q       <= len_d;
            cmd_valid_q <= cmd_valid_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.cmd_valid   = cmd_valid_q;
    assign bus.cmd_addr    = addr_q;
    assign bus.cmd_len     = len_q;
    assign bus.ctrl_done   = done_q;
    assign bus.busy        = busy_q;
    assign bus.outstanding = cnt_q;
    assign bus.rsp_err     = err_q;

endmodule
